add4_accum_ctrl: RTL and testbench

//  Sequential accumulator stage that wraps the external 4-bit ripple-carry adder.
//  It drives the adder's a/b/cin inputs and consumes its sum/cout outputs. Each batch

---
 rtl/add4_accum_ctrl.sv | 94 +++++++++
 tb/tb_add4_accum_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/add4_accum_ctrl.sv
// Batch accumulator that drives an external combinational ripple-carry adder,
// sums COUNT operands and reports the wrapped sum plus the number of carry-outs.
module add4_accum_ctrl #(
  parameter int WIDTH = 4,
  parameter int COUNT = 4,
  parameter int CW    = $clog2(COUNT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [CW-1:0]    out_carry_cnt,
  output logic             busy
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; valid never waits on ready, and a raised out_valid holds until taken.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    op_cnt;
  logic [CW-1:0]    carry_cnt;
  logic             accept;
  logic             last_op;

  assign add_a   = acc;
  assign add_b   = in_data;
  assign add_cin = 1'b0;

  assign accept  = in_valid & in_ready;
  // op_cnt is still zero in IDLE, so this also covers COUNT==1 going straight to DONE.
  assign last_op = (op_cnt == CW'(COUNT - 1));

  assign out_sum       = acc;
  assign out_carry_cnt = carry_cnt;

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (accept) state_next = last_op ? DONE : ACCUM;
      end
      ACCUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (accept && last_op) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      op_cnt    <= '0;
      carry_cnt <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        acc       <= add_sum;
        carry_cnt <= carry_cnt + CW'(add_cout);
        op_cnt    <= op_cnt + CW'(1);
      end else if (state == DONE && out_ready) begin
        acc       <= '0;
        op_cnt    <= '0;
        carry_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_add4_accum_ctrl.sv
// Self-checking bench for add4_accum_ctrl with a behavioural 4-bit adder attached
// and a scoreboard of expected batch results.
module tb_add4_accum_ctrl;
  localparam int W     = 4;
  localparam int COUNT = 4;
  localparam int CW    = $clog2(COUNT + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [W-1:0]  add_a;
  logic [W-1:0]  add_b;
  logic          add_cin;
  logic [W-1:0]  add_sum;
  logic          add_cout;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_sum;
  logic [CW-1:0] out_carry_cnt;
  logic          busy;

  int checks = 0;
  int errors = 0;

  logic [W-1:0]  exp_q[$];
  logic [CW-1:0] exp_c_q[$];

  // clock / reset
  always #5 clk = ~clk;

  // external ripple-carry adder model
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};

  add4_accum_ctrl #(.WIDTH(W), .COUNT(COUNT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_carry_cnt(out_carry_cnt), .busy(busy)
  );

  // scoreboard: pop and compare on each output handshake
  always @(negedge clk) begin
    logic [W-1:0]  s;
    logic [CW-1:0] c;
    if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL result_unexpected out_sum=%h out_carry_cnt=%0d", out_sum, out_carry_cnt);
      end else begin
        s = exp_q.pop_front();
        c = exp_c_q.pop_front();
        if (out_sum !== s || out_carry_cnt !== c) begin
          errors++;
          $display("FAIL result got sum=%h carry=%0d exp sum=%h carry=%0d",
                   out_sum, out_carry_cnt, s, c);
        end
      end
    end
  end

  // driver: COUNT operands back-to-back, model expected result, push to scoreboard
  task automatic run_batch(input logic [W-1:0] ops [COUNT], input bit chk_a,
                           output logic [W-1:0] m_acc, output logic [CW-1:0] m_c);
    logic [W:0] t;
    m_acc = '0;
    m_c   = '0;
    for (int i = 0; i < COUNT; i++) begin
      in_valid = 1'b1;
      in_data  = ops[i];
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL batch_in_ready op=%0d got=%b exp=1", i, in_ready);
      end
      if (chk_a) begin
        checks++;
        if (add_a !== m_acc) begin
          errors++;
          $display("FAIL add_a_seq op=%0d got=%h exp=%h", i, add_a, m_acc);
        end
      end
      t     = {1'b0, m_acc} + {1'b0, ops[i]};
      m_acc = t[W-1:0];
      m_c   = m_c + CW'(t[W]);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    exp_q.push_back(m_acc);
    exp_c_q.push_back(m_c);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl got in_ready=%b out_valid=%b busy=%b exp 1/0/0", in_ready, out_valid, busy);
    end
    checks++;
    if (out_sum !== 4'h0 || out_carry_cnt !== '0 || add_a !== 4'h0 || add_cin !== 1'b0) begin
      errors++;
      $display("FAIL reset_data got sum=%h carry=%0d add_a=%h cin=%b exp 0", out_sum, out_carry_cnt, add_a, add_cin);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic check_done_then_idle(input string name);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_done got out_valid=%b in_ready=%b busy=%b exp 1/0/0", name, out_valid, in_ready, busy);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== 4'h0) begin
      errors++;
      $display("FAIL %s_idle got out_valid=%b in_ready=%b out_sum=%h exp 0/1/0", name, out_valid, in_ready, out_sum);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] ops [COUNT] = '{4'h1, 4'h2, 4'h3, 4'h4};
    logic [W-1:0] s; logic [CW-1:0] c;
    run_batch(ops, 1'b0, s, c);
    check_done_then_idle("b2b_1234");
  endtask

  task automatic test_carry();
    logic [W-1:0] ops5 [COUNT] = '{4'h5, 4'h5, 4'h5, 4'h5};
    logic [W-1:0] opsf [COUNT] = '{4'hF, 4'hF, 4'hF, 4'hF};
    logic [W-1:0] s; logic [CW-1:0] c;
    run_batch(ops5, 1'b1, s, c);
    check_done_then_idle("carry_5");
    run_batch(opsf, 1'b1, s, c);
    check_done_then_idle("carry_f");
  endtask

  task automatic test_gaps();
    bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    int n = 0;
    for (int i = 0; i < 7; i++) begin
      in_valid = pat[i];
      in_data  = pat[i] ? W'(1) : W'($urandom_range(0, 15));
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || busy !== (n >= 1 && n < COUNT)) begin
        errors++;
        $display("FAIL gaps_busy cyc=%0d got in_ready=%b busy=%b exp 1/%b", i, in_ready, busy, (n >= 1 && n < COUNT));
      end
      if (pat[i]) n++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    exp_q.push_back(4'h4);
    exp_c_q.push_back('0);
    check_done_then_idle("gaps");
  endtask

  task automatic test_backpressure();
    logic [W-1:0] ops [COUNT];
    logic [W-1:0] s; logic [CW-1:0] c;
    for (int i = 0; i < COUNT; i++) ops[i] = W'($urandom_range(0, 15));
    out_ready = 1'b0;
    run_batch(ops, 1'b0, s, c);
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_data = W'($urandom_range(0, 15));
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== s || out_carry_cnt !== c) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d got v=%b rdy=%b sum=%h carry=%0d exp 1/0/%h/%0d",
                 k, out_valid, in_ready, out_sum, out_carry_cnt, s, c);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== 4'h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_release got v=%b rdy=%b sum=%h busy=%b exp 0/1/0/0", out_valid, in_ready, out_sum, busy);
    end
    @(posedge clk); #1;
    for (int i = 0; i < COUNT; i++) ops[i] = W'($urandom_range(0, 15));
    run_batch(ops, 1'b1, s, c);
    check_done_then_idle("bp_next");
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] ops [COUNT] = '{4'h2, 4'h2, 4'h2, 4'h2};
    logic [W-1:0] s; logic [CW-1:0] c;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = W'($urandom_range(1, 15));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
        out_sum !== 4'h0 || out_carry_cnt !== '0) begin
      errors++;
      $display("FAIL mid_reset got rdy=%b v=%b busy=%b sum=%h carry=%0d exp 1/0/0/0/0",
               in_ready, out_valid, busy, out_sum, out_carry_cnt);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    run_batch(ops, 1'b1, s, c);
    check_done_then_idle("after_reset");
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_carry();
    test_gaps();
    test_backpressure();
    test_reset_mid();
    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
